// File: rtl/timer_alarm_if.sv
// Handshake bundle between the alarm block and its controller / upstream 100us timer.
interface timer_alarm_if;
    logic        arm;
    logic [15:0] delta;
    logic        cancel;
    logic        ack;
    logic        timer_read;
    logic [15:0] timer_count;
    logic        busy;
    logic        irq;
    logic        err;
    logic [15:0] deadline;

    modport master (
        output arm, delta, cancel, ack, timer_count,
        input  timer_read, busy, irq, err, deadline
    );

    modport slave (
        input  arm, delta, cancel, ack, timer_count,
        output timer_read, busy, irq, err, deadline
    );
endinterface

// File: rtl/timer_alarm.sv
// One-shot alarm against a free-running 16-bit 100us tick counter; fires once the
// count reaches or passes deadline = snapshot + delta, with wrap-safe comparison.
module timer_alarm #(
    parameter logic [15:0] MAX_DELTA = 16'd32767
) (
    input  logic          clk,
    input  logic          reset,
    timer_alarm_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SNAP  = 3'd1,
        LATCH = 3'd2,
        ARMED = 3'd3,
        FIRED = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [15:0] delta_q;
    logic [15:0] deadline_q;
    logic        err_q;
    logic        delta_ok;
    logic        arm_ok;
    logic        fire;

    // Modular distance read as signed: non-negative means reached or passed,
    // valid as long as the alarm is serviced within half the counter range.
    function automatic logic reached(input logic [15:0] count, input logic [15:0] target);
        logic signed [15:0] lag;
        lag = signed'(count - target);
        return (lag >= 16'sd0);
    endfunction

    assign delta_ok = (bus.delta != 16'd0) && (bus.delta <= MAX_DELTA);
    assign arm_ok   = bus.arm && delta_ok;
    assign fire     = reached(bus.timer_count, deadline_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (arm_ok) state_nx = SNAP;
            SNAP:    state_nx = bus.cancel ? IDLE : LATCH;
            LATCH:   state_nx = bus.cancel ? IDLE : ARMED;
            ARMED: begin
                if (bus.cancel)  state_nx = IDLE;
                else if (fire)   state_nx = FIRED;
            end
            FIRED:   if (bus.ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            delta_q    <= 16'd0;
            deadline_q <= 16'd0;
            err_q      <= 1'b0;
        end else begin
            if ((state == IDLE) && bus.arm) begin
                err_q <= !delta_ok;
                if (delta_ok) delta_q <= bus.delta;
            end
            // Snapshot requested in SNAP is presented by the timer during LATCH.
            if ((state == LATCH) && !bus.cancel) begin
                deadline_q <= bus.timer_count + delta_q;
            end
        end
    end

    assign bus.timer_read = (state == SNAP) || (state == ARMED);
    assign bus.busy       = (state == SNAP) || (state == LATCH) || (state == ARMED);
    assign bus.irq        = (state == FIRED);
    assign bus.err        = err_q;
    assign bus.deadline   = deadline_q;

endmodule

// File: tb/tb_timer_alarm.sv
// Randomized and directed bench for timer_alarm against a cycle-level behavioural model.
module tb_timer_alarm;

    localparam int MAXD = 32767;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] tc = 16'h0000;

    timer_alarm_if bus();

    timer_alarm #(.MAX_DELTA(16'(MAXD))) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #40 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: age counts cycles since an accepted arm (0 = no alarm pending).
    int m_age;
    bit m_fired;
    int m_delta;
    int m_deadline;
    bit m_err;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_age      <= 0;
            m_fired    <= 1'b0;
            m_delta    <= 0;
            m_deadline <= 0;
            m_err      <= 1'b0;
        end else if (m_fired) begin
            if (bus.ack) m_fired <= 1'b0;
        end else if (m_age == 0) begin
            if (bus.arm) begin
                if (int'(bus.delta) >= 1 && int'(bus.delta) <= MAXD) begin
                    m_age   <= 1;
                    m_delta <= int'(bus.delta);
                    m_err   <= 1'b0;
                end else begin
                    m_err <= 1'b1;
                end
            end
        end else if (bus.cancel) begin
            m_age <= 0;
        end else if (m_age == 1) begin
            m_age <= 2;
        end else if (m_age == 2) begin
            m_deadline <= (int'(bus.timer_count) + m_delta) % 65536;
            m_age      <= 3;
        end else if (((int'(bus.timer_count) - m_deadline + 65536) % 65536) < 32768) begin
            m_age   <= 0;
            m_fired <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("timer_read", 16'(bus.timer_read), 16'(m_age == 1 || m_age == 3));
        chk("busy",       16'(bus.busy),       16'(m_age != 0));
        chk("irq",        16'(bus.irq),        16'(m_fired));
        chk("err",        16'(bus.err),        16'(m_err));
        chk("deadline",   bus.deadline,        16'(m_deadline));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_req(input logic [15:0] d);
        bus.arm   = 1'b1;
        bus.delta = d;
        step();
        bus.arm   = 1'b0;
    endtask

    task automatic set_tc(input logic [15:0] v);
        tc = v;
        bus.timer_count = v;
    endtask

    int r;

    initial begin
        bus.arm = 1'b0;
        bus.delta = 16'h0000;
        bus.cancel = 1'b0;
        bus.ack = 1'b0;
        set_tc(16'h0100);
        step();
        step();
        chk("rst_busy", 16'(bus.busy), 16'h0);
        chk("rst_deadline", bus.deadline, 16'h0000);
        chk("rst_err", 16'(bus.err), 16'h0);
        reset = 1'b1;
        step();

        // Basic alarm
        arm_req(16'd5);
        chk("basic_snap_read", 16'(bus.timer_read), 16'h1);
        step();
        chk("basic_latch_read", 16'(bus.timer_read), 16'h0);
        step();
        chk("basic_deadline", bus.deadline, 16'h0105);
        chk("basic_armed_read", 16'(bus.timer_read), 16'h1);
        step();
        chk("basic_no_irq", 16'(bus.irq), 16'h0);
        set_tc(16'h0105);
        step();
        chk("basic_irq", 16'(bus.irq), 16'h1);
        chk("basic_fired_read", 16'(bus.timer_read), 16'h0);
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        chk("basic_ack_irq", 16'(bus.irq), 16'h0);
        chk("basic_ack_busy", 16'(bus.busy), 16'h0);

        // Wrap-around
        set_tc(16'hFFFE);
        arm_req(16'd4);
        step();
        step();
        chk("wrap_deadline", bus.deadline, 16'h0002);
        set_tc(16'hFFFF); step(); chk("wrap_ffff", 16'(bus.irq), 16'h0);
        set_tc(16'h0000); step(); chk("wrap_0000", 16'(bus.irq), 16'h0);
        set_tc(16'h0001); step(); chk("wrap_0001", 16'(bus.irq), 16'h0);
        set_tc(16'h0002); step(); chk("wrap_0002", 16'(bus.irq), 16'h1);
        bus.ack = 1'b1; step(); bus.ack = 1'b0;

        // Rejection
        arm_req(16'd0);
        chk("rej0_err", 16'(bus.err), 16'h1);
        chk("rej0_read", 16'(bus.timer_read), 16'h0);
        arm_req(16'h8000);
        chk("rej8000_err", 16'(bus.err), 16'h1);
        chk("rej8000_busy", 16'(bus.busy), 16'h0);
        chk("rej_deadline", bus.deadline, 16'h0002);
        set_tc(16'h0010);
        arm_req(16'd3);
        chk("rej_clear_err", 16'(bus.err), 16'h0);
        step();
        step();
        chk("cancel_deadline", bus.deadline, 16'h0013);

        // Cancel in ARMED, then count runs past the deadline
        bus.cancel = 1'b1; step(); bus.cancel = 1'b0;
        chk("cancel_busy", 16'(bus.busy), 16'h0);
        chk("cancel_read", 16'(bus.timer_read), 16'h0);
        for (int i = 0; i < 6; i++) begin
            set_tc(tc + 16'd1);
            step();
            chk("cancel_no_irq", 16'(bus.irq), 16'h0);
        end

        // arm+cancel together in SNAP
        arm_req(16'd2);
        bus.arm = 1'b1; bus.delta = 16'd7; bus.cancel = 1'b1;
        step();
        bus.arm = 1'b0; bus.cancel = 1'b0;
        chk("snapcancel_busy", 16'(bus.busy), 16'h0);
        chk("snapcancel_deadline", bus.deadline, 16'h0013);

        // Ignored arm and ack while ARMED
        set_tc(16'h2000);
        arm_req(16'd5);
        step();
        step();
        chk("ign_deadline", bus.deadline, 16'h2005);
        arm_req(16'd9);
        chk("ign_arm_deadline", bus.deadline, 16'h2005);
        chk("ign_arm_err", 16'(bus.err), 16'h0);
        bus.ack = 1'b1; step(); bus.ack = 1'b0;
        chk("ign_ack_busy", 16'(bus.busy), 16'h1);
        chk("ign_ack_irq", 16'(bus.irq), 16'h0);

        // Async reset between edges while ARMED
        #10;
        reset = 1'b0;
        #1;
        chk("async_busy", 16'(bus.busy), 16'h0);
        chk("async_read", 16'(bus.timer_read), 16'h0);
        chk("async_deadline", bus.deadline, 16'h0000);
        chk("async_irq", 16'(bus.irq), 16'h0);
        set_tc(16'h3000);
        step();
        chk("async_hold_irq", 16'(bus.irq), 16'h0);
        reset = 1'b1;
        step();
        chk("async_after_irq", 16'(bus.irq), 16'h0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bus.arm = ($urandom_range(5) == 0);
            case ($urandom_range(4))
                0:       bus.delta = 16'd0;
                1:       bus.delta = 16'($urandom_range(32768, 65535));
                2:       bus.delta = 16'($urandom_range(32700, 32767));
                default: bus.delta = 16'($urandom_range(1, 24));
            endcase
            bus.cancel = ($urandom_range(39) == 0);
            bus.ack = ($urandom_range(3) == 0);
            r = $urandom_range(99);
            if (r < 60) set_tc(tc + 16'd1);
            else if (r < 63) set_tc(16'($urandom));
            if ($urandom_range(499) == 0) begin
                #9;
                reset = 1'b0;
                @(posedge clk);
                #1;
                reset = 1'b1;
                bus.arm = 1'b0;
                bus.cancel = 1'b0;
                bus.ack = 1'b0;
            end
            step();
        end

        bus.arm = 1'b0;
        bus.cancel = 1'b0;
        bus.ack = 1'b0;
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
